// File: rtl/serial_word_comparator_pkg.sv
// Shared definitions for the serial word comparator: FSM encoding and a
// constant ceil-log2 helper used to size counters and ports.
package cmp_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Ceiling log2; used only at elaboration time.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_word_comparator_bit_eq_cell.sv
// Single-bit equality cell: XNOR expressed as a product of sums.
module bit_eq_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_eq
);

  assign o_eq = (~i_a | i_b) & (i_a | ~i_b);

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial word equality stage: accumulates per-bit XNOR results over a
// WIDTH-bit word and reports match, mismatch count and first mismatch index.
module serial_word_comparator
  import cmp_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic                          i_bit_valid,
  input  logic                          i_a_bit,
  input  logic                          i_b_bit,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_match,
  output logic [clog2(WIDTH+1)-1:0]     o_mismatch_count,
  output logic [clog2(WIDTH)-1:0]       o_first_mismatch_idx,
  output logic                          o_mismatch_seen
);

  localparam int CW  = clog2(WIDTH);
  localparam int MCW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [MCW-1:0]   r_count;
  logic [CW-1:0]    r_idx;
  logic             r_seen;
  logic             r_match;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [MCW-1:0]   w_count_nxt;
  logic [CW-1:0]    w_idx_nxt;
  logic             w_seen_nxt;
  logic             w_match_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_start_ok;
  logic             w_eq;

  bit_eq_cell u_eq (
    .i_a  (i_a_bit),
    .i_b  (i_b_bit),
    .o_eq (w_eq)
  );

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_seen_nxt  = r_seen;
    w_match_nxt = r_match;
    w_done_nxt  = 1'b0;
    w_start_ok  = i_start & (r_state != ST_COMPARE);

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_COMPARE: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_match_nxt = 1'b0;
        end else if (i_bit_valid) begin
          if (!w_eq) begin
            w_count_nxt = r_count + MCW'(1);
            if (!r_seen) begin
              w_idx_nxt  = r_cnt;
              w_seen_nxt = 1'b1;
            end else begin
              w_idx_nxt  = r_idx;
            end
          end else begin
            w_count_nxt = r_count;
          end
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_match_nxt = (w_count_nxt == {MCW{1'b0}});
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end else begin
          w_state_nxt = ST_COMPARE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // An accepted start overrides whatever IDLE/DONE would have done.
    if (w_start_ok) begin
      w_state_nxt = ST_COMPARE;
      w_cnt_nxt   = {CW{1'b0}};
      w_count_nxt = {MCW{1'b0}};
      w_idx_nxt   = {CW{1'b0}};
      w_seen_nxt  = 1'b0;
      w_match_nxt = 1'b0;
    end else begin
      w_cnt_nxt   = w_cnt_nxt;
    end

    w_busy_nxt = (w_state_nxt == ST_COMPARE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_count <= {MCW{1'b0}};
      r_idx   <= {CW{1'b0}};
      r_seen  <= 1'b0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_seen  <= w_seen_nxt;
      r_match <= w_match_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_match              = r_match;
  assign o_mismatch_count     = r_count;
  assign o_first_mismatch_idx = r_idx;
  assign o_mismatch_seen      = r_seen;

endmodule
